// File: rtl/enigma_keypress_ctrl_if.sv
// Keypress and ciphertext handshake bundle for the Enigma keypress controller.
//   key_valid / key_char / key_ready : plaintext character in (0..25 = A..Z)
//   out_valid / out_char / out_ready : ciphertext character out
// The controller uses the master modport and the environment uses the slave modport.
interface enigma_keypress_ctrl_if;
    logic       key_valid;
    logic [4:0] key_char;
    logic       key_ready;
    logic       out_valid;
    logic [4:0] out_char;
    logic       out_ready;

    modport master (
        input  key_valid,
        input  key_char,
        output key_ready,
        output out_valid,
        output out_char,
        input  out_ready
    );

    modport slave (
        output key_valid,
        output key_char,
        input  key_ready,
        input  out_valid,
        input  out_char,
        output out_ready
    );
endinterface

// File: rtl/enigma_keypress_ctrl.sv
// Sequences one keypress through a three-rotor Enigma datapath: accepts a
// plaintext character, pulses the rotor step enables (including the middle-rotor
// double step), waits for the rotor/reflector path to settle, captures the
// ciphertext and presents it on a valid/ready output. Also sequences rotor loading.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   set_req           level request to load rotor start positions
//   rotor_set         one-cycle pulse to all rotors' set inputs
//   kp                key / ciphertext handshakes (master modport)
//   pos_r/m/l         current rotor positions
//   step_r/m/l        one-cycle rotor step enables
//   path_char_out     latched plaintext driven into the datapath
//   path_char_in      ciphertext returning from the datapath
//   bad_char          one-cycle pulse: an accepted character >= 26 was dropped
//   char_count        completed ciphertext handshakes (wraps)
module enigma_keypress_ctrl #(
    parameter int unsigned NOTCH_R       = 16,
    parameter int unsigned NOTCH_M       = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set_req,
    output logic                           rotor_set,
    enigma_keypress_ctrl_if.master         kp,
    input  logic [4:0]                     pos_r,
    input  logic [4:0]                     pos_m,
    input  logic [4:0]                     pos_l,
    output logic                           step_r,
    output logic                           step_m,
    output logic                           step_l,
    output logic [4:0]                     path_char_out,
    input  logic [4:0]                     path_char_in,
    output logic                           bad_char,
    output logic [15:0]                    char_count
);

    localparam logic [4:0] LP_NOTCH_R = 5'(NOTCH_R);
    localparam logic [4:0] LP_NOTCH_M = 5'(NOTCH_M);
    localparam logic [3:0] LP_SETTLE  = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_SETTLE,
        S_OUT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_settle;
    logic [4:0]  r_path_char;
    logic [4:0]  r_out_char;
    logic        r_bad_char;
    logic [15:0] r_char_count;
    logic        w_key_fire;
    logic        w_key_ok;
    logic        w_unused_pos_l;

    // The left rotor never influences stepping; its position is not needed here.
    assign w_unused_pos_l = ^pos_l;

    // A set request in IDLE blocks key acceptance in the same cycle.
    assign w_key_fire = (r_state == S_IDLE) && !set_req && kp.key_valid;
    assign w_key_ok   = (kp.key_char < 5'd26);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (set_req) begin
                    w_next = S_LOAD;
                end else if (kp.key_valid && w_key_ok) begin
                    w_next = S_STEP;
                end
            end
            S_LOAD:   w_next = S_IDLE;
            S_STEP:   w_next = S_SETTLE;
            S_SETTLE: begin
                if (r_settle == 4'd1) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (kp.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Step decisions use the pre-step positions seen during the STEP cycle;
    // a middle rotor at its notch steps itself and the left rotor (double step).
    always_comb begin
        kp.key_ready = (r_state == S_IDLE) && !set_req;
        rotor_set    = (r_state == S_LOAD);
        step_r       = (r_state == S_STEP);
        step_m       = (r_state == S_STEP) && ((pos_r == LP_NOTCH_R) || (pos_m == LP_NOTCH_M));
        step_l       = (r_state == S_STEP) && (pos_m == LP_NOTCH_M);
        kp.out_valid = (r_state == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle     <= '0;
            r_path_char  <= '0;
            r_out_char   <= '0;
            r_bad_char   <= 1'b0;
            r_char_count <= '0;
        end else begin
            r_bad_char <= w_key_fire && !w_key_ok;
            if (w_key_fire && w_key_ok) begin
                r_path_char <= kp.key_char;
            end
            if (r_state == S_STEP) begin
                r_settle <= LP_SETTLE;
            end else if (r_state == S_SETTLE) begin
                r_settle <= r_settle - 4'd1;
            end
            if ((r_state == S_SETTLE) && (r_settle == 4'd1)) begin
                r_out_char <= path_char_in;
            end
            if ((r_state == S_OUT) && kp.out_ready) begin
                r_char_count <= r_char_count + 16'd1;
            end
        end
    end

    assign path_char_out = r_path_char;
    assign kp.out_char   = r_out_char;
    assign bad_char      = r_bad_char;
    assign char_count    = r_char_count;

endmodule

// File: tb/tb_enigma_keypress_ctrl.sv
// Self-checking bench for enigma_keypress_ctrl. The bench plays the part of the
// rotors (static positions per keypress) and of the rotor/reflector path (a fixed
// arithmetic scramble of the entry character and positions).
module tb_enigma_keypress_ctrl;
    localparam int unsigned ST = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_req;
    logic        rotor_set;
    logic [4:0]  pos_r, pos_m, pos_l;
    logic        step_r, step_m, step_l;
    logic [4:0]  path_char_out;
    logic [4:0]  path_char_in;
    logic        bad_char;
    logic [15:0] char_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_count = 0;
    logic [4:0]  last_path = '0;

    enigma_keypress_ctrl_if kp ();

    enigma_keypress_ctrl #(
        .NOTCH_R(16),
        .NOTCH_M(4),
        .SETTLE_CYCLES(ST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .set_req(set_req),
        .rotor_set(rotor_set),
        .kp(kp.master),
        .pos_r(pos_r),
        .pos_m(pos_m),
        .pos_l(pos_l),
        .step_r(step_r),
        .step_m(step_m),
        .step_l(step_l),
        .path_char_out(path_char_out),
        .path_char_in(path_char_in),
        .bad_char(bad_char),
        .char_count(char_count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] scramble(input int unsigned c, input int unsigned r,
                                            input int unsigned m, input int unsigned l);
        return 5'((c * 7 + r * 3 + m * 5 + l + 11) % 26);
    endfunction

    assign path_char_in = scramble(path_char_out, pos_r, pos_m, pos_l);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_no_steps(input string tag);
        chk({tag, "_steps"}, {29'd0, step_r, step_m, step_l}, 32'd0);
    endtask

    // One full keypress; positions are held for its whole duration.
    task automatic do_key(input int unsigned k, input int unsigned pr, input int unsigned pm,
                          input int unsigned pl, input int unsigned hold);
        logic [4:0] exp_out;
        bit         em, el;
        pos_r = 5'(pr); pos_m = 5'(pm); pos_l = 5'(pl);
        kp.key_char  = 5'(k);
        kp.key_valid = 1'b1;
        #1;
        chk("idle_key_ready", kp.key_ready, 1);
        tick();
        kp.key_valid = 1'b0;
        if (k >= 26) begin
            chk("bad_pulse", bad_char, 1);
            chk_no_steps("bad");
            chk("bad_key_ready", kp.key_ready, 1);
            chk("bad_path_hold", path_char_out, last_path);
            tick();
            chk("bad_pulse_end", bad_char, 0);
            chk("bad_count", char_count, exp_count);
            return;
        end
        em = (pr == 16) || (pm == 4);
        el = (pm == 4);
        exp_out = scramble(k, pr, pm, pl);
        last_path = 5'(k);
        chk("step_r", step_r, 1);
        chk("step_m", step_m, em);
        chk("step_l", step_l, el);
        chk("step_path", path_char_out, k);
        chk("step_key_ready", kp.key_ready, 0);
        tick();
        for (int unsigned i = 0; i < ST; i++) begin
            chk("settle_valid", kp.out_valid, 0);
            chk_no_steps("settle");
            tick();
        end
        for (int unsigned i = 0; i <= hold; i++) begin
            chk("out_valid", kp.out_valid, 1);
            chk("out_char", kp.out_char, exp_out);
            chk("out_key_ready", kp.key_ready, 0);
            chk_no_steps("out");
            if (i < hold) tick();
        end
        kp.out_ready = 1'b1;
        tick();
        kp.out_ready = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        chk("count", char_count, exp_count);
        chk("post_key_ready", kp.key_ready, 1);
        chk("post_valid", kp.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k, pr, pm;
        reset = 1'b1; set_req = 1'b0;
        kp.key_valid = 1'b0; kp.key_char = '0; kp.out_ready = 1'b0;
        pos_r = '0; pos_m = '0; pos_l = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_key_ready", kp.key_ready, 1);
        chk("rst_out_valid", kp.out_valid, 0);
        chk("rst_count", char_count, 0);
        chk("rst_path", path_char_out, 0);
        chk("rst_out_char", kp.out_char, 0);
        chk("rst_bad", bad_char, 0);
        chk("rst_set", rotor_set, 0);
        chk_no_steps("rst");

        // Plain keypress at all-zero positions, then single and double steps.
        do_key(0, 0, 0, 0, 0);
        do_key(7, 16, 0, 3, 0);
        do_key(19, 5, 4, 9, 1);
        // Consumer stalls for 5 cycles.
        do_key(12, 16, 4, 25, 5);

        // Set request wins over a same-cycle key.
        set_req = 1'b1;
        kp.key_valid = 1'b1; kp.key_char = 5'd3;
        #1;
        chk("set_key_ready", kp.key_ready, 0);
        tick();
        kp.key_valid = 1'b0;
        chk("set_pulse", rotor_set, 1);
        chk_no_steps("set");
        chk("set_path_hold", path_char_out, last_path);
        set_req = 1'b0;
        tick();
        chk("set_pulse_end", rotor_set, 0);
        chk("set_idle_ready", kp.key_ready, 1);

        // Out-of-range characters are dropped.
        do_key(26, 1, 2, 3, 0);
        do_key(31, 16, 4, 3, 0);

        // Randomized keypresses with notch positions favoured.
        for (int n = 0; n < 40; n++) begin
            k  = ($urandom % 6 == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            pr = ($urandom % 3 == 0) ? 16 : $urandom_range(0, 25);
            pm = ($urandom % 3 == 0) ? 4 : $urandom_range(0, 25);
            do_key(k, pr, pm, $urandom_range(0, 25), $urandom_range(0, 3));
        end

        // Reset in the middle of SETTLE abandons the character.
        pos_r = 5'd16; pos_m = 5'd4;
        kp.key_valid = 1'b1; kp.key_char = 5'd9;
        tick();
        kp.key_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        chk("mid_rst_key_ready", kp.key_ready, 1);
        chk("mid_rst_valid", kp.out_valid, 0);
        chk("mid_rst_count", char_count, 0);
        chk_no_steps("mid_rst");
        for (int i = 0; i < ST + 2; i++) begin
            tick();
            chk("mid_rst_quiet_valid", kp.out_valid, 0);
            chk_no_steps("mid_rst_quiet");
        end
        last_path = '0;
        do_key(25, 24, 25, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
